id_stage_pipe: RTL and testbench

Parametrised pipelined instruction-decode stage for the 5-stage WISC core. It contains the register file with write-through bypass, main decode, and in-ID branch resolution. It adds load-use and branch-dependency hazard stalls, a registered ID/EX pipeline output and a sticky halt. It sits between the IF/ID register and EX, and drives the stall and redirect signals back to IF.

---
 rtl/id_stage_pipe_if.sv | 43 ++++
 rtl/id_stage_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Signal bundle between the IF/ID register, the writeback port, the ID stage and EX.
// The master modport is the surrounding pipeline; the slave modport is the ID stage.
interface id_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [DATA_W-1:0] if_pc;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        flags;
  logic              stall;
  logic              branch_take;
  logic [DATA_W-1:0] branch_target;
  logic              halted;
  logic              idex_valid;
  logic [DATA_W-1:0] idex_pc;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [REG_AW-1:0] idex_rs;
  logic [REG_AW-1:0] idex_rt;
  logic [REG_AW-1:0] idex_rd;
  logic [DATA_W-1:0] idex_imm;
  logic [6:0]        idex_ex_ctrl;
  logic [1:0]        idex_mem_ctrl;
  logic [1:0]        idex_wb_ctrl;

  modport master (
    output if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, flags,
    input  stall, branch_take, branch_target, halted, idex_valid, idex_pc,
           idex_rs_data, idex_rt_data, idex_rs, idex_rt, idex_rd, idex_imm,
           idex_ex_ctrl, idex_mem_ctrl, idex_wb_ctrl
  );

  modport slave (
    input  if_valid, if_instr, if_pc, wb_we, wb_addr, wb_data, flags,
    output stall, branch_take, branch_target, halted, idex_valid, idex_pc,
           idex_rs_data, idex_rt_data, idex_rs, idex_rt, idex_rd, idex_imm,
           idex_ex_ctrl, idex_mem_ctrl, idex_wb_ctrl
  );
endinterface

// File: rtl/id_stage_pipe.sv
// WISC pipelined decode stage: register file with write-through, decode, in-ID branch
// resolution, load-use / branch hazard stalls, registered ID/EX outputs and sticky halt.
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int REG_AW = 4
) (
  input logic           clk,
  input logic           rst_n,
  id_stage_pipe_if.slave bus
);

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [DATA_W-1:0] regs_r [NREG];

  logic [3:0]        op_s;
  logic              regwrite_s;
  logic              memread_s;
  logic              memwrite_s;
  logic              memtoreg_s;
  logic              alusrc_s;
  logic              regdst_s;
  logic              pcs_s;
  logic              is_branch_s;
  logic              is_hlt_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [REG_AW-1:0] rd_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] br_off_s;
  logic [6:0]        ex_ctrl_s;
  logic [1:0]        mem_ctrl_s;
  logic [1:0]        wb_ctrl_s;
  logic              cond_s;
  logic              idex_flag_wr_s;
  logic              load_use_s;
  logic              br_stall_s;
  logic              stall_s;
  logic              take_s;
  logic [DATA_W-1:0] target_s;
  logic              issue_s;

  logic              idex_valid_r;
  logic [DATA_W-1:0] idex_pc_r;
  logic [DATA_W-1:0] idex_rs_data_r;
  logic [DATA_W-1:0] idex_rt_data_r;
  logic [REG_AW-1:0] idex_rs_r;
  logic [REG_AW-1:0] idex_rt_r;
  logic [REG_AW-1:0] idex_rd_r;
  logic [DATA_W-1:0] idex_imm_r;
  logic [6:0]        idex_ex_ctrl_r;
  logic [1:0]        idex_mem_ctrl_r;
  logic [1:0]        idex_wb_ctrl_r;
  logic              halted_r;

  assign op_s = bus.if_instr[15:12];

  // Main control decode from the opcode.
  always_comb begin
    regwrite_s = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    memtoreg_s = 1'b0;
    alusrc_s   = 1'b0;
    regdst_s   = 1'b0;
    pcs_s      = 1'b0;
    case (op_s)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      4'h4, 4'h5, 4'h6, OP_LLB, OP_LHB: begin
        regwrite_s = 1'b1;
        alusrc_s   = 1'b1;
      end
      OP_LW: begin
        regwrite_s = 1'b1;
        alusrc_s   = 1'b1;
        memread_s  = 1'b1;
        memtoreg_s = 1'b1;
      end
      OP_SW: begin
        alusrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      4'hE: begin
        regwrite_s = 1'b1;
        pcs_s      = 1'b1;
      end
      default: begin
        regwrite_s = 1'b0;
      end
    endcase
  end

  assign is_branch_s = (op_s == OP_B) || (op_s == OP_BR);
  assign is_hlt_s    = (op_s == OP_HLT);

  // Register field selection and immediate extension.
  always_comb begin
    rd_s = REG_AW'(bus.if_instr[11:8]);
    if ((op_s == OP_LLB) || (op_s == OP_LHB)) begin
      rs_s = REG_AW'(bus.if_instr[11:8]);
    end else begin
      rs_s = REG_AW'(bus.if_instr[7:4]);
    end
    if (op_s == OP_SW) begin
      rt_s = REG_AW'(bus.if_instr[11:8]);
    end else begin
      rt_s = REG_AW'(bus.if_instr[3:0]);
    end
    if ((op_s == OP_LW) || (op_s == OP_SW)) begin
      imm_s = {{(DATA_W-5){bus.if_instr[3]}}, bus.if_instr[3:0], 1'b0};
    end else if ((op_s == OP_LLB) || (op_s == OP_LHB)) begin
      imm_s = {{(DATA_W-8){1'b0}}, bus.if_instr[7:0]};
    end else begin
      imm_s = {{(DATA_W-4){bus.if_instr[3]}}, bus.if_instr[3:0]};
    end
    br_off_s = {{(DATA_W-10){bus.if_instr[8]}}, bus.if_instr[8:0], 1'b0};
  end

  // Register file reads; a same-cycle write to the same non-zero register bypasses.
  always_comb begin
    if (rs_s == '0) begin
      rs_data_s = '0;
    end else if (bus.wb_we && (bus.wb_addr == rs_s)) begin
      rs_data_s = bus.wb_data;
    end else begin
      rs_data_s = regs_r[rs_s];
    end
    if (rt_s == '0) begin
      rt_data_s = '0;
    end else if (bus.wb_we && (bus.wb_addr == rt_s)) begin
      rt_data_s = bus.wb_data;
    end else begin
      rt_data_s = regs_r[rt_s];
    end
  end

  // Branch condition from {Z,V,N}.
  always_comb begin
    case (bus.if_instr[11:9])
      3'b000:  cond_s = ~bus.flags[2];
      3'b001:  cond_s = bus.flags[2];
      3'b010:  cond_s = ~bus.flags[2] & ~bus.flags[0];
      3'b011:  cond_s = bus.flags[0];
      3'b100:  cond_s = bus.flags[2] | (~bus.flags[2] & ~bus.flags[0]);
      3'b101:  cond_s = bus.flags[0] | bus.flags[2];
      3'b110:  cond_s = bus.flags[1];
      3'b111:  cond_s = 1'b1;
      default: cond_s = 1'b0;
    endcase
  end

  // Does the instruction now in EX update the flags a branch would test?
  always_comb begin
    case (idex_ex_ctrl_r[3:0])
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6: idex_flag_wr_s = idex_valid_r;
      default:                             idex_flag_wr_s = 1'b0;
    endcase
  end

  // Hazard detection, stall and redirect.
  always_comb begin
    load_use_s = idex_valid_r && idex_mem_ctrl_r[1] && (idex_rd_r != '0) &&
                 ((idex_rd_r == rs_s) ||
                  ((regdst_s || memwrite_s) && (idex_rd_r == rt_s)));
    br_stall_s = (is_branch_s && idex_flag_wr_s) ||
                 ((op_s == OP_BR) && idex_valid_r && idex_wb_ctrl_r[0] &&
                  (rs_s != '0) && (idex_rd_r == rs_s));
    stall_s    = (bus.if_valid && (load_use_s || br_stall_s)) || halted_r;
    take_s     = bus.if_valid && !stall_s && !halted_r && is_branch_s && cond_s;
    issue_s    = bus.if_valid && !stall_s;
    if (op_s == OP_B) begin
      target_s = bus.if_pc + br_off_s;
    end else begin
      target_s = rs_data_s;
    end
  end

  // HLT travels down the pipe as a valid slot with no control asserted.
  always_comb begin
    if (is_hlt_s) begin
      ex_ctrl_s  = 7'b0000000;
      mem_ctrl_s = 2'b00;
      wb_ctrl_s  = 2'b00;
    end else begin
      ex_ctrl_s  = {pcs_s, alusrc_s, regdst_s, op_s};
      mem_ctrl_s = {memread_s, memwrite_s};
      wb_ctrl_s  = {memtoreg_s, regwrite_s};
    end
  end

  // Register file write port; R0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_addr != '0)) begin
      regs_r[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX pipeline register: capture on issue, otherwise load a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_r    <= 1'b0;
      idex_pc_r       <= '0;
      idex_rs_data_r  <= '0;
      idex_rt_data_r  <= '0;
      idex_rs_r       <= '0;
      idex_rt_r       <= '0;
      idex_rd_r       <= '0;
      idex_imm_r      <= '0;
      idex_ex_ctrl_r  <= 7'b0000000;
      idex_mem_ctrl_r <= 2'b00;
      idex_wb_ctrl_r  <= 2'b00;
    end else if (issue_s) begin
      idex_valid_r    <= 1'b1;
      idex_pc_r       <= bus.if_pc;
      idex_rs_data_r  <= rs_data_s;
      idex_rt_data_r  <= rt_data_s;
      idex_rs_r       <= rs_s;
      idex_rt_r       <= rt_s;
      idex_rd_r       <= rd_s;
      idex_imm_r      <= imm_s;
      idex_ex_ctrl_r  <= ex_ctrl_s;
      idex_mem_ctrl_r <= mem_ctrl_s;
      idex_wb_ctrl_r  <= wb_ctrl_s;
    end else begin
      idex_valid_r    <= 1'b0;
      idex_pc_r       <= '0;
      idex_rs_data_r  <= '0;
      idex_rt_data_r  <= '0;
      idex_rs_r       <= '0;
      idex_rt_r       <= '0;
      idex_rd_r       <= '0;
      idex_imm_r      <= '0;
      idex_ex_ctrl_r  <= 7'b0000000;
      idex_mem_ctrl_r <= 2'b00;
      idex_wb_ctrl_r  <= 2'b00;
    end
  end

  // Sticky halt, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (issue_s && is_hlt_s) begin
      halted_r <= 1'b1;
    end
  end

  assign bus.stall         = stall_s;
  assign bus.branch_take   = take_s;
  assign bus.branch_target = target_s;
  assign bus.halted        = halted_r;
  assign bus.idex_valid    = idex_valid_r;
  assign bus.idex_pc       = idex_pc_r;
  assign bus.idex_rs_data  = idex_rs_data_r;
  assign bus.idex_rt_data  = idex_rt_data_r;
  assign bus.idex_rs       = idex_rs_r;
  assign bus.idex_rt       = idex_rt_r;
  assign bus.idex_rd       = idex_rd_r;
  assign bus.idex_imm      = idex_imm_r;
  assign bus.idex_ex_ctrl  = idex_ex_ctrl_r;
  assign bus.idex_mem_ctrl = idex_mem_ctrl_r;
  assign bus.idex_wb_ctrl  = idex_wb_ctrl_r;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode vector table, directed hazard/branch/halt sequences,
// and random traffic checked against an instruction-level reference model.
module tb_id_stage_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_stage_pipe_if #(.DATA_W(16), .REG_AW(4)) bus ();

  id_stage_pipe #(.DATA_W(16), .NREG(16), .REG_AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] pc, rs_d, rt_d, imm;
    logic [3:0]  rs, rt, rd;
    logic [6:0]  ex;
    logic [1:0]  mem, wb;
  } idex_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [3:0]  rs, rt, rd;
    logic [6:0]  ex;
    logic [1:0]  mem, wb;
  } vec_t;

  idex_t       m, nxt, empty;
  logic [15:0] mregs [16];
  logic        m_halted, nxt_halted;
  vec_t        vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mread(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return mregs[a];
  endfunction

  // Let inputs settle, predict this cycle's behaviour and check combinational outputs.
  task automatic settle();
    logic [15:0] ins;
    logic [3:0]  op, rs, rt;
    logic        z, v, n, cnd, lu, bs, st, tk, rdst, mw;
    logic signed [15:0] s4, s9;
    logic [15:0] tgt;
    #1;
    ins  = bus.if_instr;
    op   = ins[15:12];
    rs   = (op inside {4'hA, 4'hB}) ? ins[11:8] : ins[7:4];
    rt   = (op == 4'h9) ? ins[11:8] : ins[3:0];
    rdst = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
    mw   = (op == 4'h9);
    z = bus.flags[2]; v = bus.flags[1]; n = bus.flags[0];
    case (ins[11:9])
      3'd0: cnd = !z;
      3'd1: cnd = z;
      3'd2: cnd = !z && !n;
      3'd3: cnd = n;
      3'd4: cnd = z || (!z && !n);
      3'd5: cnd = n || z;
      3'd6: cnd = v;
      default: cnd = 1'b1;
    endcase
    lu = m.valid && (m.op == 4'h8) && m.rd != 4'd0 &&
         (m.rd == rs || ((rdst || mw) && m.rd == rt));
    bs = ((op inside {4'hC, 4'hD}) && m.valid && (m.op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6})) ||
         (op == 4'hD && m.valid && m.wb[0] && rs != 4'd0 && m.rd == rs);
    st = (bus.if_valid && (lu || bs)) || m_halted;
    tk = bus.if_valid && !st && (op inside {4'hC, 4'hD}) && cnd;
    s9 = $signed(ins[8:0]);
    tgt = (op == 4'hC) ? bus.if_pc + 16'(s9 * 2) : mread(rs);
    chk("stall", bus.stall, st);
    chk("branch_take", bus.branch_take, tk);
    if (tk) chk("branch_target", bus.branch_target, tgt);
    nxt_halted = m_halted;
    if (st || !bus.if_valid) begin
      nxt = empty;
    end else begin
      s4 = $signed(ins[3:0]);
      nxt.valid = 1'b1;
      nxt.op    = op;
      nxt.pc    = bus.if_pc;
      nxt.rs    = rs;
      nxt.rt    = rt;
      nxt.rd    = ins[11:8];
      nxt.rs_d  = mread(rs);
      nxt.rt_d  = mread(rt);
      if (op inside {4'h8, 4'h9})      nxt.imm = 16'(s4 * 2);
      else if (op inside {4'hA, 4'hB}) nxt.imm = {8'h00, ins[7:0]};
      else                             nxt.imm = s4;
      nxt.ex  = {op == 4'hE, op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}, rdst, op};
      nxt.mem = {op == 4'h8, mw};
      nxt.wb  = {op == 4'h8, op inside {[4'h0:4'h8], 4'hA, 4'hB, 4'hE}};
      if (op == 4'hF) begin
        nxt.ex = 7'd0; nxt.mem = 2'd0; nxt.wb = 2'd0;
        nxt_halted = 1'b1;
      end
    end
  endtask

  // Clock edge: advance the model and compare all registered outputs.
  task automatic edge_chk();
    @(posedge clk);
    if (bus.wb_we && bus.wb_addr != 4'd0) mregs[bus.wb_addr] = bus.wb_data;
    m = nxt;
    m_halted = nxt_halted;
    #1;
    chk("halted", bus.halted, m_halted);
    chk("idex_valid", bus.idex_valid, m.valid);
    chk("idex_pc", bus.idex_pc, m.pc);
    chk("idex_rs_data", bus.idex_rs_data, m.rs_d);
    chk("idex_rt_data", bus.idex_rt_data, m.rt_d);
    chk("idex_rs", bus.idex_rs, m.rs);
    chk("idex_rt", bus.idex_rt, m.rt);
    chk("idex_rd", bus.idex_rd, m.rd);
    chk("idex_imm", bus.idex_imm, m.imm);
    chk("idex_ex_ctrl", bus.idex_ex_ctrl, m.ex);
    chk("idex_mem_ctrl", bus.idex_mem_ctrl, m.mem);
    chk("idex_wb_ctrl", bus.idex_wb_ctrl, m.wb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_idex_valid", bus.idex_valid, 1'b0);
    chk("rst_idex_pc", bus.idex_pc, 16'h0);
    chk("rst_idex_rs_data", bus.idex_rs_data, 16'h0);
    chk("rst_idex_imm", bus.idex_imm, 16'h0);
    chk("rst_idex_regs", {bus.idex_rs, bus.idex_rt, bus.idex_rd}, 12'h0);
    chk("rst_idex_ctrl", {bus.idex_ex_ctrl, bus.idex_mem_ctrl, bus.idex_wb_ctrl}, 11'h0);
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    m = empty;
    m_halted = 1'b0;
    bus.if_valid = 1'b0;
    bus.wb_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; errors = 0; checks = 0;
    empty = '{1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 7'h0, 2'h0, 2'h0};
    m = empty; nxt = empty; m_halted = 1'b0; nxt_halted = 1'b0;
    bus.if_valid = 1'b0; bus.if_instr = 16'h0; bus.if_pc = 16'h0;
    bus.wb_we = 1'b0; bus.wb_addr = 4'h0; bus.wb_data = 16'h0; bus.flags = 3'b000;

    vt[0] = '{16'h0534, 16'h0004, 4'd3,  4'd4,  4'd5,  7'b0010000, 2'b00, 2'b01};
    vt[1] = '{16'h1FF8, 16'hFFF8, 4'd15, 4'd8,  4'd15, 7'b0010001, 2'b00, 2'b01};
    vt[2] = '{16'h4A5C, 16'hFFFC, 4'd5,  4'd12, 4'd10, 7'b0100100, 2'b00, 2'b01};
    vt[3] = '{16'h8213, 16'h0006, 4'd1,  4'd3,  4'd2,  7'b0101000, 2'b10, 2'b11};
    vt[4] = '{16'h912F, 16'hFFFE, 4'd2,  4'd1,  4'd1,  7'b0101001, 2'b01, 2'b00};
    vt[5] = '{16'hB3C5, 16'h00C5, 4'd3,  4'd5,  4'd3,  7'b0101011, 2'b00, 2'b01};
    vt[6] = '{16'hE700, 16'h0000, 4'd0,  4'd0,  4'd7,  7'b1001110, 2'b00, 2'b01};
    vt[7] = '{16'h7123, 16'h0003, 4'd2,  4'd3,  4'd1,  7'b0010111, 2'b00, 2'b01};
    vt[8] = '{16'hC3FE, 16'hFFFE, 4'd15, 4'd14, 4'd3,  7'b0001100, 2'b00, 2'b00};
    vt[9] = '{16'h3456, 16'h0006, 4'd5,  4'd6,  4'd4,  7'b0010011, 2'b00, 2'b01};

    do_reset();

    // Write-through bypass on a freshly reset register file.
    bus.wb_we = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234;
    drive(1'b1, 16'h0534, 16'h0002);
    settle(); edge_chk();
    chk("t1_bypass", bus.idex_rs_data, 16'h1234);
    chk("t1_ex_ctrl", bus.idex_ex_ctrl, 7'b0010000);
    chk("t1_wb_ctrl", bus.idex_wb_ctrl, 2'b01);
    bus.wb_we = 1'b0;

    // Load-use: exactly one bubble.
    drive(1'b1, 16'h8213, 16'h0004);
    settle(); edge_chk();
    chk("t2_imm", bus.idex_imm, 16'h0006);
    drive(1'b1, 16'h0422, 16'h0006);
    settle(); chk("t2_stall", bus.stall, 1'b1);
    edge_chk(); chk("t2_bubble", bus.idex_valid, 1'b0);
    settle(); chk("t2_release", bus.stall, 1'b0);
    edge_chk(); chk("t2_issue", bus.idex_valid, 1'b1);

    // Branch behind a flag setter.
    drive(1'b1, 16'h0111, 16'h000E);
    settle(); edge_chk();
    bus.flags = 3'b000;
    drive(1'b1, 16'hC3FE, 16'h0010);
    settle(); chk("t3_stall", bus.stall, 1'b1);
    edge_chk();
    bus.flags = 3'b100;
    settle();
    chk("t3_take", bus.branch_take, 1'b1);
    chk("t3_target", bus.branch_target, 16'h000C);
    edge_chk();

    // BR always through a register.
    drive(1'b0, 16'h0000, 16'h0000);
    bus.wb_we = 1'b1; bus.wb_addr = 4'd6; bus.wb_data = 16'h0040;
    settle(); edge_chk();
    bus.wb_we = 1'b0; bus.flags = 3'($urandom);
    drive(1'b1, 16'hDE60, 16'h0020);
    settle();
    chk("t4_take", bus.branch_take, 1'b1);
    chk("t4_target", bus.branch_target, 16'h0040);
    edge_chk();

    // LLB / SW immediates and fields.
    drive(1'b1, 16'hA7FF, 16'h0022);
    settle(); edge_chk();
    chk("t5_llb_imm", bus.idex_imm, 16'h00FF);
    chk("t5_llb_rs", bus.idex_rs, 4'd7);
    drive(1'b1, 16'h912F, 16'h0024);
    settle(); edge_chk();
    chk("t5_sw_imm", bus.idex_imm, 16'hFFFE);
    chk("t5_sw_rt", bus.idex_rt, 4'd1);
    chk("t5_sw_mem", bus.idex_mem_ctrl, 2'b01);

    // HLT, then reset while stalled.
    drive(1'b1, 16'hF000, 16'h0026);
    settle(); edge_chk();
    chk("t6_halted", bus.halted, 1'b1);
    chk("t6_hlt_valid", bus.idex_valid, 1'b1);
    chk("t6_hlt_ctrl", bus.idex_ex_ctrl, 7'b0000000);
    drive(1'b1, 16'h0534, 16'h0028);
    for (int i = 0; i < 3; i++) begin
      settle(); chk("t6_stall", bus.stall, 1'b1);
      edge_chk(); chk("t6_bubble", bus.idex_valid, 1'b0);
    end
    do_reset();

    // Decode table, each vector behind a bubble.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'h0000, 16'h0000);
      bus.flags = 3'b000;
      settle(); edge_chk();
      drive(1'b1, vt[i].instr, 16'(16'h0100 + 2 * i));
      settle(); edge_chk();
      chk("tab_valid", bus.idex_valid, 1'b1);
      chk("tab_imm", bus.idex_imm, vt[i].imm);
      chk("tab_regs", {bus.idex_rs, bus.idex_rt, bus.idex_rd}, {vt[i].rs, vt[i].rt, vt[i].rd});
      chk("tab_ex", bus.idex_ex_ctrl, vt[i].ex);
      chk("tab_mem", bus.idex_mem_ctrl, vt[i].mem);
      chk("tab_wb", bus.idex_wb_ctrl, vt[i].wb);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF) ins[15:12] = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 1) == 1) ins = ins & 16'hF333;
      drive($urandom_range(0, 9) != 0, ins, 16'($urandom));
      bus.flags   = 3'($urandom);
      bus.wb_we   = ($urandom_range(0, 2) == 0);
      bus.wb_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      bus.wb_data = 16'($urandom);
      settle(); edge_chk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
